// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the sign fix-up decision helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    function automatic logic is_div(op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    // Product and quotient flip sign when the operand signs differ.
    function automatic logic sign_fix_main(logic sign_a, logic sign_b);
        return sign_a ^ sign_b;
    endfunction

    // The remainder follows the dividend's sign.
    function automatic logic sign_fix_rem(logic sign_a);
        return sign_a;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the muldiv unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    import muldiv_pkg::*;

    logic               start_i;
    op_e                op_i;
    logic               annul_i;
    logic [WIDTH-1:0]   a_i;
    logic [WIDTH-1:0]   b_i;
    logic               busy_o;
    logic               ready_o;
    logic [2*WIDTH-1:0] result_o;
    logic               div_by_zero_o;

    modport slave (
        input  start_i, op_i, annul_i, a_i, b_i,
        output busy_o, ready_o, result_o, div_by_zero_o
    );

    modport master (
        output start_i, op_i, annul_i, a_i, b_i,
        input  busy_o, ready_o, result_o, div_by_zero_o
    );

endinterface

// File: rtl/muldiv_iter.sv
// Iterative datapath on operand magnitudes: shift-add multiply into a 2*WIDTH
// accumulator, or restoring shift-subtract divide, one step per enabled cycle.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               en_i,
    input  logic               div_i,
    input  logic [WIDTH-1:0]   a_mag_i,
    input  logic [WIDTH-1:0]   b_mag_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] prod_nxt_o,
    output logic [WIDTH-1:0]   quot_nxt_o,
    output logic [WIDTH-1:0]   rem_nxt_o
);
    localparam int CW = $clog2(WIDTH);

    // acc_q low half holds the multiplier (multiply) or dividend/quotient (divide).
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   b_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH:0]     sum, shifted, trial;

    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
    always_comb begin
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        shifted = {rem_q, acc_q[WIDTH-1]};
        trial   = shifted - {1'b0, b_q};
        acc_d   = acc_q;
        rem_d   = rem_q;
        if (div_i) begin
            rem_d            = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            acc_d = {sum, acc_q[WIDTH-1:1]};
        end
    end

    // NOTE: state updates use non-blocking assignments; reset is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
            rem_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            acc_q <= {{WIDTH{1'b0}}, a_mag_i};
            rem_q <= '0;
            b_q   <= b_mag_i;
            cnt_q <= CW'(WIDTH - 1);
        end else if (en_i) begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign last_o     = (cnt_q == '0);
    assign prod_nxt_o = acc_d;
    assign quot_nxt_o = acc_d[WIDTH-1:0];
    assign rem_nxt_o  = rem_d;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: FSM, handshake, sign capture,
// signed fix-up and the held {hi,lo} result register.
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter bit MUL_FAST = 1'b0
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    import muldiv_pkg::*;

    localparam int W2 = 2 * WIDTH;

    state_e           state_q, state_d;
    op_e              op_q;
    logic             sa_q, sb_q, dbz_q;
    logic [W2-1:0]    result_q, result_d;

    logic             in_div, in_signed, sa_in, sb_in, b_zero, fast, accept, load, last, run;
    logic [WIDTH-1:0] a_mag, b_mag, quot_nxt, rem_nxt;
    logic [W2-1:0]    prod_nxt, fast_prod;

    function automatic logic [W2-1:0] neg_wide(logic [W2-1:0] v, logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_narrow(logic [WIDTH-1:0] v, logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        in_div    = is_div(bus.op_i);
        in_signed = is_signed_op(bus.op_i);
        sa_in     = in_signed & bus.a_i[WIDTH-1];
        sb_in     = in_signed & bus.b_i[WIDTH-1];
        a_mag     = sa_in ? -bus.a_i : bus.a_i;
        b_mag     = sb_in ? -bus.b_i : bus.b_i;
        b_zero    = (bus.b_i == '0);
        fast      = in_div ? b_zero : MUL_FAST;
        accept    = (state_q != S_RUN) && bus.start_i && !bus.annul_i;
        run       = (state_q == S_RUN);
    end

    generate
        if (MUL_FAST) begin : g_fast_mul
            assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
        end else begin : g_no_fast_mul
            assign fast_prod = '0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            S_RUN: begin
                if (bus.annul_i) state_d = S_IDLE;
                else if (last)   state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    state_d = fast ? S_DONE : S_RUN;
                    load    = !fast;
                end
            end
        endcase
    end

    // Result only changes on entry to DONE; an annulled run leaves it untouched.
    always_comb begin
        result_d = result_q;
        if (accept && fast) begin
            result_d = in_div ? {bus.a_i, {WIDTH{1'b1}}}
                              : neg_wide(fast_prod, sign_fix_main(sa_in, sb_in));
        end else if (run && !bus.annul_i && last) begin
            result_d = is_div(op_q)
                ? {neg_narrow(rem_nxt, sign_fix_rem(sa_q)), neg_narrow(quot_nxt, sign_fix_main(sa_q, sb_q))}
                : neg_wide(prod_nxt, sign_fix_main(sa_q, sb_q));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MULT;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (accept) begin
                op_q  <= bus.op_i;
                sa_q  <= sa_in;
                sb_q  <= sb_in;
                dbz_q <= in_div && b_zero;
            end
        end
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .en_i       (run),
        .div_i      (is_div(op_q)),
        .a_mag_i    (a_mag),
        .b_mag_i    (b_mag),
        .last_o     (last),
        .prod_nxt_o (prod_nxt),
        .quot_nxt_o (quot_nxt),
        .rem_nxt_o  (rem_nxt)
    );

    assign bus.busy_o        = run;
    assign bus.ready_o       = (state_q == S_DONE);
    assign bus.result_o      = result_q;
    assign bus.div_by_zero_o = dbz_q;

endmodule
